// File: rtl/relu_argmax_ctrl.sv
// Final classification stage: buffers 10 signed class scores, clamps them with ReLU,
// scans for the strict maximum (lowest index wins ties) and presents class and score.
module relu_argmax_ctrl #(
   parameter int bitwidth    = 32,
   parameter int NUM_CLASSES = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [bitwidth-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [3:0]                 out_class,
   output logic signed [bitwidth-1:0] out_score,
   output logic                       busy
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RELU = 2'd1,
      S_SCAN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [3:0]                 count_q, count_d;
   logic [3:0]                 scan_idx_q, scan_idx_d;
   logic signed [bitwidth-1:0] score_q [NUM_CLASSES];
   logic signed [bitwidth-1:0] score_d [NUM_CLASSES];
   logic signed [bitwidth-1:0] best_val_q, best_val_d;
   logic [3:0]                 best_idx_q, best_idx_d;
   logic signed [bitwidth-1:0] out_score_q, out_score_d;
   logic [3:0]                 out_class_q, out_class_d;
   logic                       in_ready_q;
   logic                       out_valid_q;
   logic                       busy_q;

   // Next-state, buffer, ReLU, scan and result-capture logic.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      scan_idx_d  = scan_idx_q;
      score_d     = score_q;
      best_val_d  = best_val_q;
      best_idx_d  = best_idx_q;
      out_class_d = out_class_q;
      out_score_d = out_score_q;
      case (state_q)
         S_LOAD: begin
            if (in_valid && in_ready_q) begin
               score_d[count_q] = in_data;
               if (count_q == LAST_IDX) begin
                  count_d = 4'd0;
                  state_d = S_RELU;
               end else begin
                  count_d = count_q + 4'd1;
               end
            end else begin
               count_d = count_q;
            end
         end
         S_RELU: begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
               if (score_q[i][bitwidth-1]) begin
                  score_d[i] = {bitwidth{1'b0}};
               end else begin
                  score_d[i] = score_q[i];
               end
            end
            best_val_d = {bitwidth{1'b0}};
            best_idx_d = 4'd0;
            scan_idx_d = 4'd0;
            state_d    = S_SCAN;
         end
         S_SCAN: begin
            // Strict compare keeps the earliest index on ties.
            if (score_q[scan_idx_q] > best_val_q) begin
               best_val_d = score_q[scan_idx_q];
               best_idx_d = scan_idx_q;
            end else begin
               best_val_d = best_val_q;
            end
            if (scan_idx_q == LAST_IDX) begin
               scan_idx_d  = 4'd0;
               out_class_d = best_idx_d;
               out_score_d = best_val_d;
               state_d     = S_DONE;
            end else begin
               scan_idx_d = scan_idx_q + 4'd1;
            end
         end
         S_DONE: begin
            if (out_valid_q && out_ready) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   // State, datapath and registered handshake outputs; rst overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_LOAD;
         count_q     <= 4'd0;
         scan_idx_q  <= 4'd0;
         best_val_q  <= {bitwidth{1'b0}};
         best_idx_q  <= 4'd0;
         out_class_q <= 4'd0;
         out_score_q <= {bitwidth{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < NUM_CLASSES; i++) begin
            score_q[i] <= {bitwidth{1'b0}};
         end
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         scan_idx_q  <= scan_idx_d;
         best_val_q  <= best_val_d;
         best_idx_q  <= best_idx_d;
         out_class_q <= out_class_d;
         out_score_q <= out_score_d;
         in_ready_q  <= (state_d == S_LOAD);
         out_valid_q <= (state_d == S_DONE);
         busy_q      <= !((state_d == S_LOAD) && (count_d == 4'd0));
         for (int i = 0; i < NUM_CLASSES; i++) begin
            score_q[i] <= score_d[i];
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_class = out_class_q;
   assign out_score = out_score_q;
   assign busy      = busy_q;

endmodule
